// File: rtl/fifo_wr_arb_if.sv
// ----------------------------------------------------------------------------
// fifo_wr_arb_if
// Bundles the signals between the UART-side producers, the write arbiter
// and the FIFO write port.
//
//   req_valid   [NREQ]     per-requester beat valid
//   req_data    [NREQ*DW]  requester k data at [k*DW +: DW]
//   req_last    [NREQ]     final beat of a requester's burst
//   req_ready   [NREQ]     beat accepted when valid & ready
//   grant       [NREQ]     one-hot current owner, 0 when idle
//   wen                    FIFO write enable
//   wdata       [DW]       FIFO write data
//   wfull                  FIFO full flag
//   busy                   arbiter holds a grant
//   burst_trunc            1-cycle pulse when a burst hit the beat limit
//
// master: the environment (producers + FIFO). slave: the arbiter.
// ----------------------------------------------------------------------------
interface fifo_wr_arb_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_last;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    grant;
   logic               wen;
   logic [DW-1:0]      wdata;
   logic               wfull;
   logic               busy;
   logic               burst_trunc;

   modport master (
      output req_valid, req_data, req_last, wfull,
      input  req_ready, grant, wen, wdata, busy, burst_trunc
   );

   modport slave (
      input  req_valid, req_data, req_last, wfull,
      output req_ready, grant, wen, wdata, busy, burst_trunc
   );
endinterface

// File: rtl/fifo_wr_arb.sv
// ----------------------------------------------------------------------------
// fifo_wr_arb
// Round-robin arbiter sharing the single write port of the UART FIFO among
// NREQ requesters. A requester keeps the grant for a whole burst, which ends
// on its last beat, after MAX_BURST beats, or when it drops valid. Every
// write is gated by the FIFO full flag, so the FIFO can never overflow.
//
// Ports
//   clk    clock
//   rstn   synchronous, active-low reset
//   bus    fifo_wr_arb_if.slave
//          in : req_valid, req_data, req_last, wfull
//          out: req_ready, wen, wdata      (combinational)
//               grant, busy, burst_trunc   (registered)
//
// Timing: one arbitration cycle (IDLE) precedes every grant, then one beat
// per cycle while the owner is valid and the FIFO is not full.
// ----------------------------------------------------------------------------
module fifo_wr_arb #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int MAX_BURST = 16
) (
   input logic          clk,
   input logic          rstn,
   fifo_wr_arb_if.slave bus
);

   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t          state_reg,    state_next;
   logic [NREQ-1:0] grant_reg,    grant_next;
   logic [OW-1:0]   owner_reg,    owner_next;
   logic [OW-1:0]   rr_ptr_reg,   rr_ptr_next;
   logic [CW-1:0]   beat_cnt_reg, beat_cnt_next;
   logic            busy_reg,     busy_next;
   logic            trunc_reg,    trunc_next;

   logic [OW-1:0]   arb_idx;
   logic            any_valid;
   logic            owner_valid;
   logic            owner_last;
   logic            xfer;
   logic [NREQ-1:0] ready;
   logic [DW-1:0]   data_masked [NREQ];
   logic [DW-1:0]   wdata;

   // ------------------------------------------------------------------------
   // Per-requester datapath. grant_reg is zero outside LOCK, so it alone
   // qualifies ready and the write-data select; non-owners never see ready.
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign ready[gi]       = grant_reg[gi] & ~bus.wfull;
         assign data_masked[gi] = grant_reg[gi] ? bus.req_data[gi*DW +: DW]
                                                : '0;
      end
   endgenerate

   // AND-OR mux: at most one masked lane is non-zero.
   always_comb begin
      wdata = '0;
      for (int k = 0; k < NREQ; k++) begin
         wdata = wdata | data_masked[k];
      end
   end

   assign owner_valid = |(bus.req_valid & grant_reg);
   assign owner_last  = |(bus.req_last  & grant_reg);
   // The full flag gates the transfer itself, so wen can never rise while
   // the FIFO is full.
   assign xfer        = owner_valid & ~bus.wfull;
   assign any_valid   = |bus.req_valid;

   // ------------------------------------------------------------------------
   // Round-robin pick: first valid index at rr_ptr+1, rr_ptr+2, ... mod NREQ.
   // Scanning from the farthest offset down lets the nearest one win last.
   // ------------------------------------------------------------------------
   always_comb begin
      logic [OW-1:0] cand;
      arb_idx = '0;
      cand    = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = OW'((int'(rr_ptr_reg) + k) % NREQ);
         if (bus.req_valid[cand]) begin
            arb_idx = cand;
         end
      end
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg    <= IDLE;
         grant_reg    <= '0;
         owner_reg    <= '0;
         rr_ptr_reg   <= OW'(NREQ - 1);   // requester 0 wins the first tie
         beat_cnt_reg <= '0;
         busy_reg     <= 1'b0;
         trunc_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         owner_reg    <= owner_next;
         rr_ptr_reg   <= rr_ptr_next;
         beat_cnt_reg <= beat_cnt_next;
         busy_reg     <= busy_next;
         trunc_reg    <= trunc_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      grant_next    = grant_reg;
      owner_next    = owner_reg;
      rr_ptr_next   = rr_ptr_reg;
      beat_cnt_next = beat_cnt_reg;
      trunc_next    = 1'b0;

      unique case (state_reg)
         IDLE: begin
            // Arbitration bubble: the owner is chosen here, no beat moves.
            if (any_valid) begin
               state_next          = LOCK;
               owner_next          = arb_idx;
               grant_next          = '0;
               grant_next[arb_idx] = 1'b1;
               beat_cnt_next       = '0;
            end
         end

         LOCK: begin
            if (!owner_valid) begin
               // Owner went away: release without a transfer this cycle.
               state_next    = IDLE;
               grant_next    = '0;
               rr_ptr_next   = owner_reg;
               beat_cnt_next = '0;
            end else if (xfer) begin
               if (owner_last || (beat_cnt_reg == CW'(MAX_BURST - 1))) begin
                  state_next    = IDLE;
                  grant_next    = '0;
                  rr_ptr_next   = owner_reg;
                  beat_cnt_next = '0;
                  // A burst that ends exactly on the limit with last set
                  // is a normal completion, not a truncation.
                  trunc_next    = ~owner_last;
               end else begin
                  beat_cnt_next = beat_cnt_reg + CW'(1);
               end
            end
            // Owner valid but FIFO full: hold grant and count.
         end

         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase

      busy_next = (state_next == LOCK);
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.req_ready   = ready;
   assign bus.wen         = xfer;
   assign bus.wdata       = wdata;
   assign bus.grant       = grant_reg;
   assign bus.busy        = busy_reg;
   assign bus.burst_trunc = trunc_reg;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arb
// Directed bench for fifo_wr_arb (NREQ=4, DW=8, MAX_BURST=16). Each producer
// k sends beats {k[1:0], seq[5:0]}; every cycle the scoreboard checks that a
// write carries the owner's current beat, that wen matches the handshake,
// that wen never coincides with full, and that grant/ready stay legal.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arb;

   localparam int NREQ      = 4;
   localparam int DW        = 8;
   localparam int MAX_BURST = 16;

   logic clk;
   logic rstn;

   fifo_wr_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

   fifo_wr_arb #(
      .NREQ      (NREQ),
      .DW        (DW),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Producer model: rem = beats left, lmode 0 = last on final beat,
   // 1 = last on every beat, 2 = never last; en masks valid.
   int         rem    [NREQ];
   logic [5:0] seq    [NREQ];
   int         lmode  [NREQ];
   bit         en     [NREQ];
   int         wr_cnt [NREQ];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < NREQ; k++) begin
         bus.req_valid[k]        = en[k] && (rem[k] > 0);
         bus.req_data[k*DW +: DW] = {2'(k), seq[k]};
         bus.req_last[k]         = (rem[k] > 0) &&
                                   ((lmode[k] == 1) ||
                                    (lmode[k] == 0 && rem[k] == 1));
      end
   endtask

   // One clock cycle: scoreboard on settled signals, edge, producer update,
   // redrive, settle.
   task automatic cycle();
      logic [NREQ-1:0] acc;
      int owner;
      owner = 0;
      for (int k = 0; k < NREQ; k++) if (bus.grant[k]) owner = k;
      chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
      chk("ready_owner_only", 32'(bus.req_ready & ~bus.grant), 32'd0);
      acc = bus.req_valid & bus.req_ready;
      chk("wen_handshake", 32'(bus.wen), 32'(|acc));
      if (bus.wen) begin
         chk("wen_while_full", 32'(bus.wfull), 32'd0);
         chk("wdata_order", 32'(bus.wdata), 32'({2'(owner), seq[owner]}));
         wr_cnt[owner]++;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
         if (acc[k]) begin
            seq[k] = seq[k] + 6'd1;
            rem[k] = rem[k] - 1;
         end
      end
      drive();
      #1;
   endtask

   task automatic clear_producers();
      for (int k = 0; k < NREQ; k++) begin
         rem[k]    = 0;
         seq[k]    = '0;
         lmode[k]  = 0;
         en[k]     = 1'b1;
         wr_cnt[k] = 0;
      end
      bus.wfull = 1'b0;
      drive();
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      clear_producers();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstn = 1'b1;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      clear_producers();

      // ---------------- Reset state ----------------
      do_reset();
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_trunc", 32'(bus.burst_trunc), 32'd0);
      chk("rst_wen", 32'(bus.wen), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);

      // ---------------- T1: req1, 3 beats 41,42,43 ----------------
      rem[1] = 3; seq[1] = 6'd1; drive(); #1;
      chk("t1_c1_grant", 32'(bus.grant), 32'd0);
      chk("t1_c1_wen", 32'(bus.wen), 32'd0);
      cycle();
      chk("t1_c2_grant", 32'(bus.grant), 32'b0010);
      chk("t1_c2_busy", 32'(bus.busy), 32'd1);
      chk("t1_c2_wen", 32'(bus.wen), 32'd1);
      chk("t1_c2_wdata", 32'(bus.wdata), 32'h41);
      chk("t1_c2_ready", 32'(bus.req_ready), 32'b0010);
      cycle();
      chk("t1_c3_wdata", 32'(bus.wdata), 32'h42);
      cycle();
      chk("t1_c4_wdata", 32'(bus.wdata), 32'h43);
      chk("t1_c4_wen", 32'(bus.wen), 32'd1);
      cycle();
      chk("t1_c5_grant", 32'(bus.grant), 32'd0);
      chk("t1_c5_busy", 32'(bus.busy), 32'd0);
      chk("t1_c5_wen", 32'(bus.wen), 32'd0);
      chk("t1_count", 32'(wr_cnt[1]), 32'd3);

      // ---------------- T2: 4-way 1-beat bursts ----------------
      do_reset();
      for (int k = 0; k < NREQ; k++) begin
         rem[k] = 100; lmode[k] = 1;
      end
      drive(); #1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("t2_wen_%0d", i), 32'(bus.wen), 32'(i % 2));
         if (i % 2 == 1)
            chk($sformatf("t2_grant_%0d", i), 32'(bus.grant),
                32'(1 << ((i / 2) % 4)));
         cycle();
      end
      // Last release was by req0.
      for (int k = 0; k < NREQ; k++) rem[k] = 0;
      drive(); #1;
      cycle();
      chk("t2_idle", 32'(bus.grant), 32'd0);

      // ---------------- T3: req2 20 beats, truncation ----------------
      for (int k = 0; k < NREQ; k++) begin
         lmode[k] = 0; wr_cnt[k] = 0;
      end
      rem[2] = 20; lmode[2] = 2;
      rem[3] = 2;
      drive(); #1;
      chk("t3_idle", 32'(bus.grant), 32'd0);
      cycle();
      for (int j = 0; j < MAX_BURST; j++) begin
         chk($sformatf("t3_grant_%0d", j), 32'(bus.grant), 32'b0100);
         chk($sformatf("t3_wen_%0d", j), 32'(bus.wen), 32'd1);
         chk($sformatf("t3_trunc_%0d", j), 32'(bus.burst_trunc), 32'd0);
         cycle();
      end
      chk("t3_trunc_pulse", 32'(bus.burst_trunc), 32'd1);
      chk("t3_rel_grant", 32'(bus.grant), 32'd0);
      chk("t3_rel_busy", 32'(bus.busy), 32'd0);
      cycle();
      chk("t3_trunc_clear", 32'(bus.burst_trunc), 32'd0);
      chk("t3_req3_grant", 32'(bus.grant), 32'b1000);
      chk("t3_req3_wen", 32'(bus.wen), 32'd1);
      cycle();
      chk("t3_req3_beat2", 32'(bus.wen), 32'd1);
      cycle();
      chk("t3_gap", 32'(bus.grant), 32'd0);
      chk("t3_no_trunc_last", 32'(bus.burst_trunc), 32'd0);
      cycle();
      chk("t3_req2_regrant", 32'(bus.grant), 32'b0100);
      for (int j = 0; j < 6; j++) cycle();
      chk("t3_req2_count", 32'(wr_cnt[2]), 32'd20);
      chk("t3_req3_count", 32'(wr_cnt[3]), 32'd2);
      chk("t3_done", 32'(bus.grant), 32'd0);

      // ---------------- T4: full stall mid-burst ----------------
      for (int k = 0; k < NREQ; k++) wr_cnt[k] = 0;
      rem[0] = 6; seq[0] = 6'd0;
      drive(); #1;
      cycle();
      chk("t4_grant", 32'(bus.grant), 32'b0001);
      cycle();
      cycle();
      bus.wfull = 1'b1; #1;
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("t4_stall_wen_%0d", j), 32'(bus.wen), 32'd0);
         chk($sformatf("t4_stall_ready_%0d", j), 32'(bus.req_ready), 32'd0);
         chk($sformatf("t4_stall_grant_%0d", j), 32'(bus.grant), 32'b0001);
         cycle();
      end
      bus.wfull = 1'b0; #1;
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("t4_resume_wdata_%0d", j), 32'(bus.wdata),
             32'(8'h02 + 8'(j)));
         cycle();
      end
      chk("t4_released", 32'(bus.grant), 32'd0);
      chk("t4_count", 32'(wr_cnt[0]), 32'd6);

      // ---------------- T5: owner drops valid ----------------
      rem[1] = 4; rem[3] = 1;
      drive(); #1;
      cycle();
      chk("t5_grant", 32'(bus.grant), 32'b0010);
      cycle();
      cycle();
      en[1] = 1'b0; drive(); #1;
      chk("t5_drop_wen", 32'(bus.wen), 32'd0);
      cycle();
      chk("t5_rel_grant", 32'(bus.grant), 32'd0);
      chk("t5_rel_busy", 32'(bus.busy), 32'd0);
      chk("t5_rel_trunc", 32'(bus.burst_trunc), 32'd0);
      cycle();
      chk("t5_req3_grant", 32'(bus.grant), 32'b1000);
      chk("t5_req3_wen", 32'(bus.wen), 32'd1);
      cycle();
      chk("t5_req1_beats", 32'(rem[1]), 32'd2);
      rem[1] = 0; en[1] = 1'b1; drive(); #1;
      cycle();

      // ---------------- T6: reset during LOCK ----------------
      rem[1] = 10;
      drive(); #1;
      cycle();
      chk("t6_grant", 32'(bus.grant), 32'b0010);
      cycle();
      cycle();
      rem[0] = 5; rem[2] = 5; rem[3] = 5;
      rstn = 1'b0; drive(); #1;
      cycle();
      chk("t6_rst_grant", 32'(bus.grant), 32'd0);
      chk("t6_rst_busy", 32'(bus.busy), 32'd0);
      chk("t6_rst_wen", 32'(bus.wen), 32'd0);
      rstn = 1'b1; #1;
      cycle();
      chk("t6_tie_req0", 32'(bus.grant), 32'b0001);
      chk("t6_tie_wen", 32'(bus.wen), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
